// File: rtl/instr_fetch_if.sv
// Bus bundle for the instruction fetch unit: fetch control, BRAM read port
// and the decoder-facing instruction stream.
interface instr_fetch_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          en;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          mem_en;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;

    // Fetch unit side.
    modport master (
        input  en, redirect, redirect_pc, mem_rdata, out_ready,
        output mem_en, mem_addr, out_valid, out_instr, out_pc, count
    );

    // Environment side: core control, BRAM and decoder.
    modport slave (
        output en, redirect, redirect_pc, mem_rdata, out_ready,
        input  mem_en, mem_addr, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit with a DEPTH-entry prefetch buffer in front of a
// one-cycle-latency instruction BRAM. Reads are issued only when a buffer
// slot is guaranteed for the returning word (credit = count + in-flight).
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module instr_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic          pend;
    logic [31:0]   pend_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] fill_count;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];

    logic [CW:0]   credit_used;
    logic          issue;
    logic          push;
    logic          pop;

    // Credit check uses the occupancy before this cycle's push/pop; holding
    // reads off during reset keeps mem_en low while rst is asserted.
    assign credit_used = {1'b0, fill_count} + {{CW{1'b0}}, pend};
    assign issue = rst & bus.en & ~bus.redirect & (credit_used < (CW+1)'(DEPTH));
    assign push  = pend & ~bus.redirect;
    assign pop   = (fill_count != '0) & bus.out_ready & ~bus.redirect;

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = fetch_pc;
    assign bus.out_valid = (fill_count != '0);
    assign bus.out_instr = buf_instr[head];
    assign bus.out_pc    = buf_pc[head];
    assign bus.count     = fill_count;

    // Fetch PC, in-flight tracking and buffer pointers; redirect flushes all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            pend       <= 1'b0;
            pend_pc    <= 32'h0;
            head       <= '0;
            tail       <= '0;
            fill_count <= '0;
        end else if (bus.redirect) begin
            fetch_pc   <= bus.redirect_pc;
            pend       <= 1'b0;
            head       <= '0;
            tail       <= '0;
            fill_count <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd1;
                pend_pc  <= fetch_pc;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   fill_count <= fill_count + CW'(1);
                2'b01:   fill_count <= fill_count - CW'(1);
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Buffer storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= bus.mem_rdata;
            buf_pc[tail]    <= pend_pc;
        end
    end
endmodule
